// File: rtl/logic_unit_seq_pkg.sv
// Shared opcodes, FSM encodings and opcode classification for logic_unit_seq.
package logic_unit_seq_pkg;

    localparam logic [3:0] OP_NOT1  = 4'b0000;
    localparam logic [3:0] OP_NOT2  = 4'b0001;
    localparam logic [3:0] OP_XNOR  = 4'b0010;
    localparam logic [3:0] OP_NOR   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NAND  = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_POPCNT = 4'b1000;
    localparam logic [3:0] OP_CLZ    = 4'b1001;
    localparam logic [3:0] OP_CTZ    = 4'b1010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    function automatic logic is_count_op(input logic [3:0] op);
        return (op == OP_POPCNT) || (op == OP_CLZ) || (op == OP_CTZ);
    endfunction

endpackage

// File: rtl/logic_unit_seq_bit_count_slice.sv
// Combinational statistics over one CHUNK-bit slice; the top chains these
// across cycles to build full-width POPCNT/CLZ/CTZ.
module bit_count_slice
    import logic_unit_seq_pkg::*;
#(
    parameter int CHUNK = 8,
    localparam int CW   = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] slice,
    output logic [CW-1:0]    pop_cnt,
    output logic [CW-1:0]    lz_cnt,
    output logic [CW-1:0]    tz_cnt,
    output logic             any_one
);

    logic seen_hi;
    logic seen_lo;

    // Population count plus leading/trailing zero runs; an empty slice yields CHUNK zeros.
    always_comb begin
        pop_cnt = '0;
        lz_cnt  = '0;
        tz_cnt  = '0;
        seen_hi = 1'b0;
        seen_lo = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            pop_cnt = pop_cnt + CW'(slice[i]);
            if (slice[i]) begin
                seen_lo = 1'b1;
            end else if (!seen_lo) begin
                tz_cnt = tz_cnt + CW'(1);
            end
            if (slice[CHUNK-1-i]) begin
                seen_hi = 1'b1;
            end else if (!seen_hi) begin
                lz_cnt = lz_cnt + CW'(1);
            end
        end
        any_one = |slice;
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Handshaked logic unit: single-cycle bitwise ops and fixed-latency
// iterative bit counts behind a one-entry output register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a new request whenever the output slot can drain
// ST_COUNT | walking the latched operand one CHUNK slice per cycle
module logic_unit_seq
    import logic_unit_seq_pkg::*;
#(
    parameter int OPD_LENGTH = 32,
    parameter int CHUNK      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPD_LENGTH-1:0] opd1,
    input  logic [OPD_LENGTH-1:0] opd2,
    input  logic [3:0]            alu_op_select,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPD_LENGTH-1:0] logic_result,
    output logic                  op_error,
    output logic                  busy
);

    localparam int N     = OPD_LENGTH / CHUNK;
    localparam int CNT_W = $clog2(OPD_LENGTH + 1);
    localparam int CW    = $clog2(CHUNK + 1);
    localparam int SC_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(N - 1);

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [OPD_LENGTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic                  found_q, found_d;
    logic [SC_W-1:0]       slice_cnt_q, slice_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [OPD_LENGTH-1:0] res_q, res_d;
    logic                  err_q, err_d;

    logic [CHUNK-1:0]      slice;
    logic [CW-1:0]         pop_cnt, lz_cnt, tz_cnt;
    logic                  any_one;
    logic [OPD_LENGTH-1:0] bw_res;
    logic                  bw_ok;
    logic                  accept;

    // CLZ walks MSB-first; POPCNT/CTZ walk LSB-first.
    assign slice = (op_q == OP_CLZ) ? shreg_q[OPD_LENGTH-1 -: CHUNK] : shreg_q[CHUNK-1:0];

    bit_count_slice #(.CHUNK(CHUNK)) u_slice (
        .slice   (slice),
        .pop_cnt (pop_cnt),
        .lz_cnt  (lz_cnt),
        .tz_cnt  (tz_cnt),
        .any_one (any_one)
    );

    assign in_ready     = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign busy         = (state_q == ST_COUNT);
    assign out_valid    = out_valid_q;
    assign logic_result = res_q;
    assign op_error     = err_q;

    // Single-cycle bitwise result; anything unrecognised (count ops included) flags not-ok.
    always_comb begin
        bw_res = '0;
        bw_ok  = 1'b1;
        case (alu_op_select)
            OP_AND:  bw_res = opd1 & opd2;
            OP_OR:   bw_res = opd1 | opd2;
            OP_XOR:  bw_res = opd1 ^ opd2;
            OP_NOT1: bw_res = ~opd1;
            OP_NOT2: bw_res = ~opd2;
            OP_NAND: bw_res = ~(opd1 & opd2);
            OP_NOR:  bw_res = ~(opd1 | opd2);
            OP_XNOR: bw_res = ~(opd1 ^ opd2);
            default: bw_ok  = 1'b0;
        endcase
    end

    // Next-state, count accumulation and output-slot management.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        found_d     = found_q;
        slice_cnt_d = slice_cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        res_d       = res_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_count_op(alu_op_select)) begin
                        state_d     = ST_COUNT;
                        op_d        = alu_op_select;
                        shreg_d     = opd1;
                        acc_d       = '0;
                        found_d     = 1'b0;
                        slice_cnt_d = SC_LAST;
                    end else begin
                        out_valid_d = 1'b1;
                        res_d       = bw_res;
                        err_d       = !bw_ok;
                    end
                end
            end
            ST_COUNT: begin
                if (op_q == OP_CLZ) begin
                    shreg_d = shreg_q << CHUNK;
                end else begin
                    shreg_d = shreg_q >> CHUNK;
                end
                case (op_q)
                    OP_POPCNT: acc_d = acc_q + CNT_W'(pop_cnt);
                    OP_CLZ:    if (!found_q) acc_d = acc_q + CNT_W'(lz_cnt);
                    OP_CTZ:    if (!found_q) acc_d = acc_q + CNT_W'(tz_cnt);
                    default:   acc_d = acc_q;
                endcase
                if (any_one) begin
                    found_d = 1'b1;
                end
                slice_cnt_d = slice_cnt_q - SC_W'(1);
                if (slice_cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    res_d       = OPD_LENGTH'(acc_d);
                    err_d       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            shreg_q     <= '0;
            acc_q       <= '0;
            found_q     <= 1'b0;
            slice_cnt_q <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            found_q     <= found_d;
            slice_cnt_q <= slice_cnt_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: expectations are queued at accept
// and compared when the result handshake completes.
module tb_logic_unit_seq;

    localparam int W  = 32;
    localparam int CH = 8;
    localparam int N  = W / CH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] opd1 = '0;
    logic [W-1:0] opd2 = '0;
    logic [3:0]   alu_op_select = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] logic_result;
    logic         op_error;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic         err;
        logic [W-1:0] res;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    logic_unit_seq #(.OPD_LENGTH(W), .CHUNK(CH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opd1          (opd1),
        .opd2          (opd2),
        .alu_op_select (alu_op_select),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .logic_result  (logic_result),
        .op_error      (op_error),
        .busy          (busy)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   k;
        e.err = 1'b0;
        e.res = '0;
        k = 0;
        case (op)
            4'b0111: e.res = a & b;
            4'b0110: e.res = a | b;
            4'b0100: e.res = a ^ b;
            4'b0000: e.res = ~a;
            4'b0001: e.res = ~b;
            4'b0101: e.res = ~(a & b);
            4'b0011: e.res = ~(a | b);
            4'b0010: e.res = ~(a ^ b);
            4'b1000: for (int i = 0; i < W; i++) e.res = e.res + W'(a[i]);
            4'b1001: begin
                while (k < W && !a[W-1-k]) k++;
                e.res = W'(k);
            end
            4'b1010: begin
                while (k < W && !a[k]) k++;
                e.res = W'(k);
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: drain compare first, then enqueue a new accept on the same edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result: got err=%0b res=%h with nothing pending", op_error, logic_result);
                end else begin
                    mon_e = sb.pop_front();
                    if ({op_error, logic_result} !== mon_e) begin
                        miscompares++;
                        $display("FAIL sb_result: got err=%0b res=%h, expected err=%0b res=%h",
                                 op_error, logic_result, mon_e.err, mon_e.res);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(alu_op_select, opd1, opd2));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        alu_op_select = op;
        opd1 = a;
        opd2 = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, op_error, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got valid/err/busy=%b, expected 000", {out_valid, op_error, busy});
        end
        vectors++;
        if (logic_result !== '0) begin
            miscompares++;
            $display("FAIL reset_result: got %h, expected 0", logic_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %0b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bitwise();
        logic [3:0] ops[5];
        ops = '{4'b0110, 4'b0100, 4'b0000, 4'b0001, 4'b0101};
        out_ready = 1'b1;
        issue(4'b0111, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        vectors++;
        if (out_valid !== 1'b1 || logic_result !== 32'h00F0_000F) begin
            miscompares++;
            $display("FAIL and_latency: got valid=%0b res=%h, expected 1 00f0000f", out_valid, logic_result);
        end
        issue(4'b0011, 32'h1234_5678, 32'h0F0F_0000);
        vectors++;
        if (out_valid !== 1'b1 || logic_result !== 32'hE0C0_A987) begin
            miscompares++;
            $display("FAIL nor_b2b: got valid=%0b res=%h, expected 1 e0c0a987", out_valid, logic_result);
        end
        issue(4'b0010, 32'hFFFF_0000, 32'hF0F0_F0F0);
        vectors++;
        if (out_valid !== 1'b1 || logic_result !== 32'hF0F0_0F0F) begin
            miscompares++;
            $display("FAIL xnor_b2b: got valid=%0b res=%h, expected 1 f0f00f0f", out_valid, logic_result);
        end
        foreach (ops[i]) begin
            issue(ops[i], $urandom, $urandom);
            vectors++;
            if (out_valid !== 1'b1 || op_error !== 1'b0) begin
                miscompares++;
                $display("FAIL bitwise_latency op=%b: got valid=%0b err=%0b, expected 1 0", ops[i], out_valid, op_error);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_count();
        logic [3:0]   ops[8];
        logic [W-1:0] opa[8];
        logic [W-1:0] expv[8];
        int           cyc;
        logic         rdy_seen;
        ops  = '{4'b1000, 4'b1001, 4'b1010, 4'b1001, 4'b1010, 4'b1000, 4'b1001, 4'b1010};
        opa  = '{32'h8000_0001, 32'h0001_0000, 32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        expv = '{32'd2, 32'd15, 32'd32, 32'd32, 32'd31, 32'd32, 32'd0, 32'd0};
        out_ready = 1'b1;
        foreach (ops[i]) begin
            issue(ops[i], opa[i], $urandom);
            cyc = 0;
            rdy_seen = 1'b0;
            while (busy && cyc < 20) begin
                if (in_ready) rdy_seen = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
            end
            vectors++;
            if (cyc != N || rdy_seen) begin
                miscompares++;
                $display("FAIL count_busy op=%b: got %0d busy cycles (in_ready seen=%0b), expected %0d and 0", ops[i], cyc, rdy_seen, N);
            end
            vectors++;
            if (out_valid !== 1'b1 || logic_result !== expv[i] || op_error !== 1'b0) begin
                miscompares++;
                $display("FAIL count_result op=%b opd=%h: got valid=%0b res=%0d, expected 1 %0d", ops[i], opa[i], out_valid, logic_result, expv[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_invalid();
        out_ready = 1'b1;
        issue(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
        vectors++;
        if (out_valid !== 1'b1 || op_error !== 1'b1 || logic_result !== '0) begin
            miscompares++;
            $display("FAIL invalid_op: got valid=%0b err=%0b res=%h, expected 1 1 0", out_valid, op_error, logic_result);
        end
        issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        vectors++;
        if (op_error !== 1'b1 || logic_result !== '0) begin
            miscompares++;
            $display("FAIL invalid_op_1011: got err=%0b res=%h, expected 1 0", op_error, logic_result);
        end
        issue(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000);
        vectors++;
        if (op_error !== 1'b0 || logic_result !== 32'h5555_5555) begin
            miscompares++;
            $display("FAIL err_clear: got err=%0b res=%h, expected 0 55555555", op_error, logic_result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = $urandom;
        b = $urandom;
        out_ready = 1'b0;
        issue(4'b0100, a, b);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || logic_result !== (a ^ b)) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: got in_ready=%0b valid=%0b res=%h, expected 0 1 %h",
                         i, in_ready, out_valid, logic_result, a ^ b);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(4'b0111, a, b);
        vectors++;
        if (out_valid !== 1'b1 || logic_result !== (a & b)) begin
            miscompares++;
            $display("FAIL drain_refill: got valid=%0b res=%h, expected 1 %h", out_valid, logic_result, a & b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_count();
        logic leaked;
        int   cyc;
        out_ready = 1'b1;
        issue(4'b1001, 32'h0001_0000, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: got busy=%0b valid=%0b, expected 0 0", busy, out_valid);
        end
        leaked = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        vectors++;
        if (leaked) begin
            miscompares++;
            $display("FAIL abort_no_output: got out_valid=1 after abort, expected 0");
        end
        @(posedge clk);
        #1;
        issue(4'b1000, 32'hFFFF_0000, 32'h0);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (out_valid !== 1'b1 || logic_result !== 32'd16) begin
            miscompares++;
            $display("FAIL post_abort_op: got valid=%0b res=%0d, expected 1 16", out_valid, logic_result);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_bitwise();
        test_count();
        test_invalid();
        test_backpressure();
        test_reset_mid_count();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d results outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
